// File: rtl/clock_period_monitor_pkg.sv
// Shared types and helpers for the slow-clock period monitor and the
// divider-side benches that need the same counter width.
package clock_period_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMING  = 2'd1,
    MEASURE = 2'd2
  } cpm_state_e;

  // Wide enough to hold EXPECTED+TOLERANCE+1, the longest reportable period.
  function automatic int cpm_cnt_w(input int expected, input int tolerance);
    return $clog2(expected + tolerance + 2);
  endfunction

endpackage

// File: rtl/sync_rise_detect.sv
// Multi-flop synchroniser for an asynchronous level, followed by a registered
// rising-edge detector. Reusable for any slow asynchronous input.
module sync_rise_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   prev_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= '0;
      prev_p1 <= 1'b0;
      rise    <= 1'b0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], async_in};
      prev_p1 <= sync_p0[SYNC_STAGES-1];
      rise    <= sync_p0[SYNC_STAGES-1] & ~prev_p1;
    end
  end

endmodule

// File: rtl/clock_period_monitor.sv
// Measures the rise-to-rise period of a slow asynchronous clock in system
// cycles, flags out-of-window periods and stuck input, and reports lock.
module clock_period_monitor
  import clock_period_monitor_pkg::*;
#(
  parameter int  EXPECTED    = 128,
  parameter int  TOLERANCE   = 2,
  parameter int  SYNC_STAGES = 2,
  parameter int  LOCK_COUNT  = 4,
  localparam int CNT_W       = cpm_cnt_w(EXPECTED, TOLERANCE)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             clk_in,
  output logic             edge_pulse,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             err_fast,
  output logic             err_slow,
  output logic             locked
);

  localparam int               GOOD_W   = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] P_MIN    = CNT_W'(EXPECTED - TOLERANCE);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(EXPECTED + TOLERANCE);
  localparam logic [GOOD_W-1:0] GOOD_MAX = GOOD_W'(LOCK_COUNT);

  function automatic logic [GOOD_W-1:0] sat_inc(input logic [GOOD_W-1:0] g);
    return (g == GOOD_MAX) ? g : g + 1'b1;
  endfunction

  logic              rise;
  cpm_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, p_new;
  logic [GOOD_W-1:0] good_q, good_d, good_inc;
  logic [CNT_W-1:0]  period_d;
  logic              pv_d, ef_d, es_d, locked_d;

  sync_rise_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (clk_in),
    .rise     (rise)
  );

  assign p_new    = cnt_q + 1'b1;
  assign good_inc = sat_inc(good_q);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    good_d   = good_q;
    period_d = period;
    pv_d     = 1'b0;
    ef_d     = 1'b0;
    es_d     = 1'b0;
    locked_d = locked;
    if (!enable) begin
      // Dropping enable discards any partial measurement without a report.
      state_d  = IDLE;
      cnt_d    = '0;
      good_d   = '0;
      locked_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = ARMING;
          cnt_d   = '0;
        end
        ARMING: begin
          if (rise) begin
            cnt_d   = '0;
            state_d = MEASURE;
          end
        end
        MEASURE: begin
          // A rise wins over a coincident timeout so that period is reported.
          if (rise) begin
            cnt_d    = '0;
            period_d = p_new;
            pv_d     = 1'b1;
            if (p_new < P_MIN) begin
              ef_d     = 1'b1;
              good_d   = '0;
              locked_d = 1'b0;
            end else if (p_new > CNT_MAX) begin
              es_d     = 1'b1;
              good_d   = '0;
              locked_d = 1'b0;
            end else begin
              good_d   = good_inc;
              locked_d = (good_inc == GOOD_MAX);
            end
          end else if (cnt_q == CNT_MAX) begin
            es_d     = 1'b1;
            good_d   = '0;
            locked_d = 1'b0;
            cnt_d    = '0;
            state_d  = ARMING;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      good_q       <= '0;
      edge_pulse   <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
      err_fast     <= 1'b0;
      err_slow     <= 1'b0;
      locked       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      good_q       <= good_d;
      edge_pulse   <= rise;
      period       <= period_d;
      period_valid <= pv_d;
      err_fast     <= ef_d;
      err_slow     <= es_d;
      locked       <= locked_d;
    end
  end

endmodule

// File: tb/tb_clock_period_monitor.sv
// Bench for clock_period_monitor: scenario tasks drive clk_in/enable/rst_n
// cycle by cycle and compare against an elapsed-time reference model.
`timescale 1ns/1ps
module tb_clock_period_monitor;
  localparam int EXPECTED    = 128;
  localparam int TOLERANCE   = 2;
  localparam int SYNC_STAGES = 2;
  localparam int LOCK_COUNT  = 4;
  localparam int CNT_W       = $clog2(EXPECTED + TOLERANCE + 2);
  localparam int P_LO        = EXPECTED - TOLERANCE;
  localparam int P_HI        = EXPECTED + TOLERANCE;
  localparam int PH_OFF = 0, PH_WAIT = 1, PH_RUN = 2;

  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, clk_in = 1'b0;
  logic edge_pulse, period_valid, err_fast, err_slow, locked;
  logic [CNT_W-1:0] period;

  clock_period_monitor #(
    .EXPECTED(EXPECTED), .TOLERANCE(TOLERANCE),
    .SYNC_STAGES(SYNC_STAGES), .LOCK_COUNT(LOCK_COUNT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clk_in(clk_in),
    .edge_pulse(edge_pulse), .period(period), .period_valid(period_valid),
    .err_fast(err_fast), .err_slow(err_slow), .locked(locked)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0, cyc = 0;
  logic [2:0] stim[$];  // {rst_n, enable, clk_in} per clk cycle

  // Reference model: rise seen SYNC_STAGES+1 edges after sampling, then
  // periods are plain differences of rise times.
  int m_phase, m_last, m_good, m_period, m_reports;
  logic m_locked, m_sprev, e_ep, e_pv, e_ef, e_es;
  logic [SYNC_STAGES:0] m_rpipe;

  task automatic model_reset();
    m_phase = PH_OFF; m_last = 0; m_good = 0; m_period = 0; m_locked = 1'b0;
    m_sprev = 1'b0; m_rpipe = '0;
    e_ep = 1'b0; e_pv = 1'b0; e_ef = 1'b0; e_es = 1'b0;
  endtask

  task automatic model_edge();
    logic r_act;
    int   el;
    e_ep = 1'b0; e_pv = 1'b0; e_ef = 1'b0; e_es = 1'b0;
    if (!rst_n) begin
      model_reset();
      return;
    end
    r_act   = m_rpipe[SYNC_STAGES];
    m_rpipe = {m_rpipe[SYNC_STAGES-1:0], clk_in & ~m_sprev};
    m_sprev = clk_in;
    e_ep    = r_act;
    if (!enable) begin
      m_phase = PH_OFF; m_good = 0; m_locked = 1'b0;
    end else if (m_phase == PH_OFF) begin
      m_phase = PH_WAIT;
    end else if (m_phase == PH_WAIT) begin
      if (r_act) begin m_phase = PH_RUN; m_last = cyc; end
    end else begin
      el = cyc - m_last;
      if (r_act) begin
        m_period = el; e_pv = 1'b1; m_last = cyc; m_reports++;
        if (el < P_LO) begin
          e_ef = 1'b1; m_good = 0; m_locked = 1'b0;
        end else if (el > P_HI) begin
          e_es = 1'b1; m_good = 0; m_locked = 1'b0;
        end else begin
          if (m_good < LOCK_COUNT) m_good++;
          m_locked = (m_good == LOCK_COUNT);
        end
      end else if (el == P_HI + 1) begin
        e_es = 1'b1; m_good = 0; m_locked = 1'b0; m_phase = PH_WAIT;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    model_edge();
  endtask

  function automatic logic [CNT_W+4:0] obs_vec();
    return {edge_pulse, period_valid, err_fast, err_slow, locked, period};
  endfunction

  function automatic logic [CNT_W+4:0] exp_vec();
    return {e_ep, e_pv, e_ef, e_es, m_locked, CNT_W'(m_period)};
  endfunction

  task automatic add_const(input int n, input logic ci, input logic en, input logic rn);
    for (int i = 0; i < n; i++) stim.push_back({rn, en, ci});
  endtask

  task automatic add_wave(input int hi, input int lo, input int n);
    for (int k = 0; k < n; k++) begin
      add_const(hi, 1'b1, 1'b1, 1'b1);
      add_const(lo, 1'b0, 1'b1, 1'b1);
    end
  endtask

  task automatic test_reset();
    int n_ep, n_other;
    n_ep = 0; n_other = 0;
    rst_n = 1'b0; enable = 1'b0;
    for (int i = 0; i < 20; i++) begin
      clk_in = i[1];
      tick();
      n_chk++;
      if (obs_vec() !== '0) $display("FAIL reset_hold cyc=%0d got=%h want=0", cyc, obs_vec());
      else n_pass++;
    end
    clk_in = 1'b0;
    rst_n  = 1'b1;
    add_const(4, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      add_const(10, 1'b1, 1'b0, 1'b1);
      add_const(10, 1'b0, 1'b0, 1'b1);
    end
    while (stim.size() != 0) begin
      {rst_n, enable, clk_in} = stim.pop_front();
      tick();
      n_chk++;
      if (obs_vec() !== exp_vec()) $display("FAIL reset_idle cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
      else n_pass++;
      if (edge_pulse) n_ep++;
      if (period_valid || err_fast || err_slow || locked) n_other++;
    end
    n_chk++;
    if (n_ep !== 3) $display("FAIL idle_edges got=%0d want=3", n_ep); else n_pass++;
    n_chk++;
    if (n_other !== 0) $display("FAIL idle_quiet got=%0d want=0", n_other); else n_pass++;
  endtask

  task automatic test_nominal_lock();
    int n_rep, lock_rep, first_ep_pv, bad_per;
    logic lk_prev;
    n_rep = 0; lock_rep = -1; first_ep_pv = -1; bad_per = 0; lk_prev = locked;
    add_const($urandom_range(3, 20), 1'b0, 1'b1, 1'b1);
    add_wave(64, 64, 7);
    while (stim.size() != 0) begin
      {rst_n, enable, clk_in} = stim.pop_front();
      tick();
      n_chk++;
      if (obs_vec() !== exp_vec()) $display("FAIL nominal cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
      else n_pass++;
      if (edge_pulse && first_ep_pv < 0) first_ep_pv = int'(period_valid);
      if (period_valid) begin
        n_rep++;
        if (int'(period) != EXPECTED) bad_per++;
      end
      if (locked && !lk_prev && lock_rep < 0) lock_rep = period_valid ? n_rep : -2;
      lk_prev = locked;
    end
    n_chk++;
    if (first_ep_pv !== 0) $display("FAIL first_edge_pv got=%0d want=0", first_ep_pv); else n_pass++;
    n_chk++;
    if (n_rep !== 6 || bad_per !== 0) $display("FAIL nominal_reports got=%0d/%0d bad want=6/0", n_rep, bad_per); else n_pass++;
    n_chk++;
    if (lock_rep !== LOCK_COUNT) $display("FAIL lock_at_report got=%0d want=%0d", lock_rep, LOCK_COUNT); else n_pass++;
    n_chk++;
    if (locked !== 1'b1) $display("FAIL nominal_locked got=%b want=1", locked); else n_pass++;
  endtask

  task automatic test_fast_relock();
    int n120, first_ok, n_rep;
    n120 = 0; first_ok = -1; n_rep = 0;
    add_wave(60, 60, 2);
    add_wave(64, 64, 5);
    while (stim.size() != 0) begin
      {rst_n, enable, clk_in} = stim.pop_front();
      tick();
      n_chk++;
      if (obs_vec() !== exp_vec()) $display("FAIL fast cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
      else n_pass++;
      if (period_valid) n_rep++;
      if (period_valid && int'(period) == 120) begin
        if (n120 == 0) first_ok = int'(err_fast && !locked && !err_slow);
        n120++;
      end
    end
    n_chk++;
    if (first_ok !== 1 || n120 !== 2) $display("FAIL fast_flag got=%0d/%0d want=1/2", first_ok, n120); else n_pass++;
    n_chk++;
    if (n_rep !== 7 || locked !== 1'b1) $display("FAIL relock got=%0d/%b want=7/1", n_rep, locked); else n_pass++;
  endtask

  task automatic test_window_edges();
    int want_p[6];
    logic [1:0] want_f[6];
    logic want_l[6];
    int got_p[$];
    logic [1:0] got_f[$];
    logic got_l[$];
    want_p = '{128, 126, 130, 125, 131, 128};
    want_f = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b01, 2'b00};
    want_l = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    add_wave(63, 63, 1);
    add_wave(65, 65, 1);
    add_wave(62, 63, 1);
    add_wave(65, 66, 1);
    add_wave(64, 64, 2);
    while (stim.size() != 0) begin
      {rst_n, enable, clk_in} = stim.pop_front();
      tick();
      n_chk++;
      if (obs_vec() !== exp_vec()) $display("FAIL window cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
      else n_pass++;
      if (period_valid) begin
        got_p.push_back(int'(period));
        got_f.push_back({err_fast, err_slow});
        got_l.push_back(locked);
      end
    end
    n_chk++;
    if (got_p.size() !== 6) $display("FAIL window_count got=%0d want=6", got_p.size());
    else begin
      n_pass++;
      for (int i = 0; i < 6; i++) begin
        n_chk++;
        if (got_p[i] !== want_p[i] || got_f[i] !== want_f[i] || got_l[i] !== want_l[i])
          $display("FAIL window_%0d got=%0d/%b/%b want=%0d/%b/%b", i, got_p[i], got_f[i], got_l[i],
                   want_p[i], want_f[i], want_l[i]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_stuck();
    int last_ep, n_es, es_delta, es_per, n_pv, n_ep, first_rep_ep, first_per;
    logic es_pv, es_lk, lk_before, lk_prev;
    last_ep = 0; n_es = 0; es_delta = -1; es_per = -1; es_pv = 1'b1; es_lk = 1'b1;
    lk_before = 1'b0; lk_prev = locked;
    add_wave(64, 64, 5);
    add_const(64, 1'b1, 1'b1, 1'b1);
    add_const(300, 1'b0, 1'b1, 1'b1);
    while (stim.size() != 0) begin
      {rst_n, enable, clk_in} = stim.pop_front();
      tick();
      n_chk++;
      if (obs_vec() !== exp_vec()) $display("FAIL stuck cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
      else n_pass++;
      if (edge_pulse) last_ep = cyc;
      if (err_slow) begin
        n_es++; es_delta = cyc - last_ep; es_pv = period_valid;
        es_per = int'(period); es_lk = locked; lk_before = lk_prev;
      end
      lk_prev = locked;
    end
    n_chk++;
    if (n_es !== 1) $display("FAIL stuck_count got=%0d want=1", n_es); else n_pass++;
    // Timeout lands on the edge where a rise would have measured P_HI+1.
    n_chk++;
    if (es_delta !== P_HI + 1) $display("FAIL stuck_delay got=%0d want=%0d", es_delta, P_HI + 1); else n_pass++;
    n_chk++;
    if (es_pv !== 1'b0 || es_per !== EXPECTED || es_lk !== 1'b0 || lk_before !== 1'b1)
      $display("FAIL stuck_state got=%b/%0d/%b/%b want=0/%0d/0/1", es_pv, es_per, es_lk, lk_before, EXPECTED);
    else n_pass++;
    n_pv = 0; n_ep = 0; first_rep_ep = -1; first_per = -1;
    add_wave(64, 64, 3);
    while (stim.size() != 0) begin
      {rst_n, enable, clk_in} = stim.pop_front();
      tick();
      n_chk++;
      if (obs_vec() !== exp_vec()) $display("FAIL rearm cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
      else n_pass++;
      if (edge_pulse) n_ep++;
      if (period_valid) begin
        if (n_pv == 0) begin first_rep_ep = n_ep; first_per = int'(period); end
        n_pv++;
      end
    end
    n_chk++;
    if (n_pv !== 2 || first_rep_ep !== 2 || first_per !== EXPECTED)
      $display("FAIL rearm_report got=%0d/%0d/%0d want=2/2/%0d", n_pv, first_rep_ep, first_per, EXPECTED);
    else n_pass++;
  endtask

  task automatic test_abort(input logic use_reset);
    logic aborted, prev_rst, lk_at_abort, lk_after;
    int n_ep, n_pv, first_rep_ep, first_per;
    aborted = 1'b0; lk_at_abort = 1'b0; lk_after = 1'b1;
    n_ep = 0; n_pv = 0; first_rep_ep = -1; first_per = -1;
    add_wave(64, 64, 5);
    add_const(40, 1'b1, 1'b1, 1'b1);
    add_const(10, 1'b0, 1'b1, 1'b1);
    if (use_reset) add_const(1, 1'b0, 1'b1, 1'b0);
    else           add_const(1, 1'b0, 1'b0, 1'b1);
    add_const(77, 1'b0, 1'b1, 1'b1);
    add_wave(64, 64, 3);
    while (stim.size() != 0) begin
      prev_rst = rst_n;
      {rst_n, enable, clk_in} = stim.pop_front();
      if (!aborted && (!rst_n || !enable)) begin
        aborted = 1'b1;
        lk_at_abort = m_locked;
        if (!rst_n && prev_rst) begin
          #1;
          n_chk++;
          if (obs_vec() !== '0) $display("FAIL async_reset got=%h want=0", obs_vec());
          else n_pass++;
        end
        tick();
        lk_after = locked;
      end else begin
        tick();
      end
      n_chk++;
      if (obs_vec() !== exp_vec()) $display("FAIL abort%0d cyc=%0d got=%h want=%h", use_reset, cyc, obs_vec(), exp_vec());
      else n_pass++;
      if (aborted) begin
        if (edge_pulse) n_ep++;
        if (period_valid) begin
          if (n_pv == 0) begin first_rep_ep = n_ep; first_per = int'(period); end
          n_pv++;
        end
      end
    end
    n_chk++;
    if (lk_at_abort !== 1'b1 || lk_after !== 1'b0)
      $display("FAIL abort%0d_lock got=%b/%b want=1/0", use_reset, lk_at_abort, lk_after);
    else n_pass++;
    n_chk++;
    if (n_pv !== 2 || first_rep_ep !== 2 || first_per !== EXPECTED)
      $display("FAIL abort%0d_report got=%0d/%0d/%0d want=2/2/%0d", use_reset, n_pv, first_rep_ep, first_per, EXPECTED);
    else n_pass++;
  endtask

  task automatic test_random();
    int p, hi, dpos, obs_rep, start_rep;
    logic drop;
    obs_rep = 0; start_rep = m_reports;
    for (int k = 0; k < 16; k++) begin
      p    = $urandom_range(116, 140);
      hi   = $urandom_range(2, p - 2);
      drop = ($urandom_range(0, 7) == 0);
      dpos = $urandom_range(0, p - 1);
      for (int c = 0; c < p; c++)
        stim.push_back({1'b1, !(drop && c == dpos), c < hi});
    end
    add_wave(64, 64, 1);
    while (stim.size() != 0) begin
      {rst_n, enable, clk_in} = stim.pop_front();
      tick();
      n_chk++;
      if (obs_vec() !== exp_vec()) $display("FAIL random cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
      else n_pass++;
      if (period_valid) obs_rep++;
    end
    n_chk++;
    if (obs_rep !== m_reports - start_rep)
      $display("FAIL random_reports got=%0d want=%0d", obs_rep, m_reports - start_rep);
    else n_pass++;
  endtask

  initial begin
    m_reports = 0;
    model_reset();
    test_reset();
    test_nominal_lock();
    test_fast_relock();
    test_window_edges();
    test_stuck();
    test_abort(1'b0);
    test_abort(1'b1);
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d limit reached", cyc);
    $fatal(1, "watchdog");
  end

endmodule
